instr_mem_fetch: RTL and testbench
==================================

Name: instr_mem_fetch

Overview:
- Parametrised instruction ROM/RAM with a valid/ready fetch interface and a word-wide loader port; the successor to the combinational instruction memory.
- Sits between the PC/fetch stage and decode; the loader port is used by the testbench or boot logic to program the image before or between runs.
- Adds a registered one-cycle read, backpressure, address translation from the text base, and fault reporting for misaligned or out-of-range PCs.

Parameters:
- DATA_W, 32, instruction width in bits.
- ADDR_W, 32, PC/byte-address width.
- DEPTH, 64, number of instruction words; must be a power of 2, at least 2.
- BASE_ADDR, 32'h0040_0000, byte address of word 0 (start of the text segment).
- NOP_INSTR, 32'h0000_0000, instruction returned on a faulted fetch.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- load_we  in  1  loader write strobe.
- load_idx  in  $clog2(DEPTH)  word index to write.
- load_data  in  DATA_W  word to write.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  fetch request can be accepted this cycle.
- req_pc  in  ADDR_W  byte address to fetch.
- rsp_valid  out  1  response holds a fetched word.
- rsp_ready  in  1  consumer accepts the response.
- rsp_instr  out  DATA_W  fetched instruction.
- rsp_fault  out  2  00 ok, 01 misaligned, 10 out-of-range; misaligned wins if both apply.
- rsp_pc  out  ADDR_W  PC of the request that produced this response.

Behaviour:
- Reset is synchronous to clk, active-low: one rising edge with rst_n=0 resets the block.
  - On reset: rsp_valid=0, rsp_instr=0, rsp_fault=0, rsp_pc=0.
  - Memory contents are NOT cleared.
  - req_ready follows its combinational equation once rst_n=1.
- Loader:
  - When load_we=1, mem[load_idx] <= load_data at the edge.
  - load_we ignored while rst_n=0.
- req_ready = rst_n && !load_we && (!rsp_valid || rsp_ready).
  - A load blocks fetch acceptance, so there is no read/write collision on mem.
- Request accepted when req_valid && req_ready (accept cycle N).
- Address translation:
  - off = req_pc - BASE_ADDR, ADDR_W-bit unsigned with wrap.
  - Misaligned if req_pc[1:0] != 0.
  - Out-of-range if off >= DEPTH*4; a PC below BASE_ADDR wraps to a large off and is therefore out-of-range.
  - idx = off[$clog2(DEPTH)+1:2].
- Response, latency exactly 1 cycle: at edge N+1, rsp_valid=1 and rsp_pc=req_pc.
  - No fault: rsp_instr = mem[idx] as it was before edge N+1, rsp_fault=00.
  - Fault: rsp_instr = NOP_INSTR, rsp_fault=01 or 10.
- Hold rule: while rsp_valid && !rsp_ready, rsp_* stay stable and req_ready=0.
- Response handoff:
  - If rsp_ready=1 with no new accept, rsp_valid drops to 0 at the next edge.
  - Accept and drain in the same cycle: the new response replaces the old one; full throughput is 1 fetch/cycle.
- req_valid=0: no state change apart from draining.
- Reset mid-operation: a pending response is discarded, rsp_valid=0 at the next edge; an in-flight accept that same cycle is dropped.
- State is the 1-entry response register: EMPTY (rsp_valid=0) or FULL (rsp_valid=1).
  - EMPTY to FULL on accept.
  - FULL to EMPTY on drain with no accept.
  - FULL to FULL on hold, or on drain plus accept.

Decomposition:
- Package instr_mem_pkg:
  - fault_t enum: FAULT_NONE=2'b00, FAULT_MISALIGN=2'b01, FAULT_RANGE=2'b10.
  - Default BASE_ADDR and NOP_INSTR constants.
- One sub-module, instr_mem_array: a DEPTH x DATA_W synchronous-write, synchronous-read array with a single read and a single write port.
- The top holds the address check, handshake and response register.

Test Plan:
- Load, then fetch:
  - Stimulus: load idx0=32'h2008_0005 and idx1=32'h2009_000A; fetch PC 32'h0040_0000, then 32'h0040_0004, with rsp_ready=1.
  - Response: rsp_valid one cycle after each accept; instr 32'h2008_0005 then 32'h2009_000A; fault=00; back-to-back throughput.
- Backpressure:
  - Stimulus: fetch 0x0040_0000 with rsp_ready=0 for 3 cycles.
  - Response: req_ready=0; rsp_instr and rsp_pc stable for 3 cycles; the next request is accepted the cycle rsp_ready=1.
- Faults:
  - PC 32'h0040_0002 gives fault=01 and instr=NOP_INSTR.
  - PC 32'h0040_0100 with DEPTH=64 gives fault=10.
  - PC 32'h003F_FFFC gives fault=10.
  - PC 32'h0040_0101 gives fault=01 (misaligned wins).
- Load priority:
  - Stimulus: assert load_we and req_valid together.
  - Response: req_ready=0 and no accept. A fetch of the same index in the following cycle returns the newly written word.
- Reset:
  - Stimulus: rst_n=0 for one edge while rsp_valid=1 and a request is pending.
  - Response: rsp_valid, rsp_instr, rsp_fault and rsp_pc all 0 after the edge; memory contents survive, checked by re-fetching idx0 = 32'h2008_0005.
- Top index and wrap:
  - Stimulus: DEPTH=8; load idx7=32'hDEAD_BEEF; fetch 32'h0040_001C, then 32'h0040_0020.
  - Response: 32'hDEAD_BEEF with fault=00, then fault=10.

Source files
------------

// File: rtl/instr_mem_pkg.sv
// Shared types and defaults for the instruction memory fetch block.
//   fault_t        : response fault code (none / misaligned / out-of-range)
//   rsp_state_e    : occupancy of the 1-entry response register
//   classify_fault : fault priority, misalignment wins over range
package instr_mem_pkg;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_RANGE    = 2'b10
  } fault_t;

  typedef enum logic [0:0] {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } rsp_state_e;

  localparam logic [31:0] DefaultBaseAddr = 32'h0040_0000;
  localparam logic [31:0] DefaultNopInstr = 32'h0000_0000;

  function automatic fault_t classify_fault(logic misalign, logic out_of_range);
    if (misalign) begin
      return FAULT_MISALIGN;
    end else if (out_of_range) begin
      return FAULT_RANGE;
    end
    return FAULT_NONE;
  endfunction

endpackage

// File: rtl/instr_mem_array.sv
// DEPTH x DATA_W word array, one synchronous write port and one registered read port.
//   clk_i   : clock
//   we_i    : write strobe; waddr_i / wdata_i : write index / data
//   re_i    : read enable; raddr_i : read index
//   rdata_o : read data, updated one edge after re_i, held otherwise
module instr_mem_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Contents are deliberately never reset so an image survives a core reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_mem_fetch.sv
// Instruction memory with valid/ready fetch, 1-cycle registered read and fault reporting.
//   clk, rst_n (sync, active-low)
//   load_we / load_idx / load_data : loader write port (blocks fetch acceptance)
//   req_valid / req_ready / req_pc : fetch request (byte PC)
//   rsp_valid / rsp_ready          : response handshake
//   rsp_instr / rsp_fault / rsp_pc : fetched word, fault code, originating PC
module instr_mem_fetch
  import instr_mem_pkg::*;
#(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DEPTH     = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DefaultBaseAddr),
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(DefaultNopInstr)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_we,
  input  logic [$clog2(DEPTH)-1:0] load_idx,
  input  logic [DATA_W-1:0]        load_data,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_pc,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_instr,
  output logic [1:0]               rsp_fault,
  output logic [ADDR_W-1:0]        rsp_pc
);

  localparam int unsigned       IdxW      = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] SpanBytes = ADDR_W'(DEPTH * 4);

  rsp_state_e        state_q, state_d;
  fault_t            fault_q, fault_d;
  logic [ADDR_W-1:0] pc_q;
  // ok_q selects the array read data; otherwise alt_q (0 after reset, NOP after a fault).
  logic              ok_q;
  logic [DATA_W-1:0] alt_q;

  logic              accept;
  logic [ADDR_W-1:0] off;
  logic [IdxW-1:0]   rd_idx;
  logic [DATA_W-1:0] rd_data;

  assign rsp_valid = (state_q == StFull);
  assign req_ready = rst_n && !load_we && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;

  // A PC below the base wraps to a huge offset and lands in the range fault.
  assign off     = req_pc - BASE_ADDR;
  assign rd_idx  = off[IdxW+1:2];
  assign fault_d = classify_fault(|req_pc[1:0], off >= SpanBytes);

  instr_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk_i   (clk),
    .we_i    (load_we && rst_n),
    .waddr_i (load_idx),
    .wdata_i (load_data),
    .re_i    (accept && (fault_d == FAULT_NONE)),
    .raddr_i (rd_idx),
    .rdata_o (rd_data)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (accept) state_d = StFull;
      StFull:  if (rsp_ready && !accept) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      fault_q <= FAULT_NONE;
      pc_q    <= '0;
      ok_q    <= 1'b0;
      alt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        fault_q <= fault_d;
        pc_q    <= req_pc;
        ok_q    <= (fault_d == FAULT_NONE);
        alt_q   <= NOP_INSTR;
      end
    end
  end

  assign rsp_instr = ok_q ? rd_data : alt_q;
  assign rsp_fault = fault_q;
  assign rsp_pc    = pc_q;

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Directed bench for instr_mem_fetch: a DEPTH=64 instance for the main flow and a
// DEPTH=8 instance for the top-index / wrap case.
module tb_instr_mem_fetch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH = 64 instance
  logic        rst_n, load_we, req_valid, req_ready, rsp_valid, rsp_ready;
  logic [5:0]  load_idx;
  logic [31:0] load_data, req_pc, rsp_instr, rsp_pc;
  logic [1:0]  rsp_fault;

  // DEPTH = 8 instance
  logic        s_rst_n, s_load_we, s_req_valid, s_req_ready, s_rsp_valid, s_rsp_ready;
  logic [2:0]  s_load_idx;
  logic [31:0] s_load_data, s_req_pc, s_rsp_instr, s_rsp_pc;
  logic [1:0]  s_rsp_fault;

  int n_cmp = 0;
  int n_err = 0;

  instr_mem_fetch #(.DEPTH(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_we   (load_we),
    .load_idx  (load_idx),
    .load_data (load_data),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_pc    (req_pc),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_fault (rsp_fault),
    .rsp_pc    (rsp_pc)
  );

  instr_mem_fetch #(.DEPTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (s_rst_n),
    .load_we   (s_load_we),
    .load_idx  (s_load_idx),
    .load_data (s_load_data),
    .req_valid (s_req_valid),
    .req_ready (s_req_ready),
    .req_pc    (s_req_pc),
    .rsp_valid (s_rsp_valid),
    .rsp_ready (s_rsp_ready),
    .rsp_instr (s_rsp_instr),
    .rsp_fault (s_rsp_fault),
    .rsp_pc    (s_rsp_pc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rsp(input string tag, input logic [31:0] instr, input logic [1:0] fault,
                           input logic [31:0] pc);
    check({tag, ".valid"}, 32'(rsp_valid), 32'd1);
    check({tag, ".instr"}, rsp_instr, instr);
    check({tag, ".fault"}, 32'(rsp_fault), 32'(fault));
    check({tag, ".pc"}, rsp_pc, pc);
  endtask

  logic [31:0] fault_pc [4] = '{32'h0040_0002, 32'h0040_0100, 32'h003F_FFFC, 32'h0040_0101};
  logic [1:0]  fault_ex [4] = '{2'b01, 2'b10, 2'b10, 2'b01};

  initial begin
    rst_n = 1'b0; load_we = 1'b0; load_idx = '0; load_data = '0;
    req_valid = 1'b0; req_pc = '0; rsp_ready = 1'b0;
    s_rst_n = 1'b0; s_load_we = 1'b0; s_load_idx = '0; s_load_data = '0;
    s_req_valid = 1'b0; s_req_pc = '0; s_rsp_ready = 1'b0;

    // Reset state
    step();
    check("rst.valid", 32'(rsp_valid), 32'd0);
    check("rst.instr", rsp_instr, 32'd0);
    check("rst.fault", 32'(rsp_fault), 32'd0);
    check("rst.pc", rsp_pc, 32'd0);
    check("rst.ready_low", 32'(req_ready), 32'd0);
    rst_n = 1'b1; s_rst_n = 1'b1;
    #1;
    check("idle.ready", 32'(req_ready), 32'd1);

    // Load priority: load and request together, request must not be accepted
    load_we = 1'b1; load_idx = 6'd0; load_data = 32'h2008_0005;
    req_valid = 1'b1; req_pc = 32'h0040_0000; rsp_ready = 1'b1;
    #1;
    check("ldprio.ready", 32'(req_ready), 32'd0);
    step();
    check("ldprio.noacc0", 32'(rsp_valid), 32'd0);
    load_idx = 6'd1; load_data = 32'h2009_000A;
    step();
    check("ldprio.noacc1", 32'(rsp_valid), 32'd0);

    // Fetch back-to-back; idx1 was written the previous cycle
    load_we = 1'b0;
    #1;
    check("fetch.ready", 32'(req_ready), 32'd1);
    step();
    check_rsp("fetch0", 32'h2008_0005, 2'b00, 32'h0040_0000);
    req_pc = 32'h0040_0004;
    #1;
    check("fetch.b2b_ready", 32'(req_ready), 32'd1);
    step();
    check_rsp("fetch1", 32'h2009_000A, 2'b00, 32'h0040_0004);

    // Drain with no new request
    req_valid = 1'b0;
    step();
    check("drain.valid", 32'(rsp_valid), 32'd0);

    // Backpressure: hold response for 3 cycles with a pending request
    req_valid = 1'b1; req_pc = 32'h0040_0000; rsp_ready = 1'b0;
    step();
    check_rsp("bp.first", 32'h2008_0005, 2'b00, 32'h0040_0000);
    req_pc = 32'h0040_0004;
    for (int i = 0; i < 3; i++) begin
      check("bp.ready", 32'(req_ready), 32'd0);
      step();
      check_rsp("bp.hold", 32'h2008_0005, 2'b00, 32'h0040_0000);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp.release_ready", 32'(req_ready), 32'd1);
    step();
    check_rsp("bp.next", 32'h2009_000A, 2'b00, 32'h0040_0004);

    // Faults
    for (int i = 0; i < 4; i++) begin
      req_pc = fault_pc[i];
      step();
      check_rsp("fault", 32'h0000_0000, fault_ex[i], fault_pc[i]);
    end

    // Reset while full with a request pending
    req_pc = 32'h0040_0004; rst_n = 1'b0;
    step();
    check("midrst.valid", 32'(rsp_valid), 32'd0);
    check("midrst.instr", rsp_instr, 32'd0);
    check("midrst.fault", 32'(rsp_fault), 32'd0);
    check("midrst.pc", rsp_pc, 32'd0);
    rst_n = 1'b1; req_pc = 32'h0040_0000;
    step();
    check_rsp("midrst.refetch", 32'h2008_0005, 2'b00, 32'h0040_0000);
    req_valid = 1'b0;
    step();
    check("midrst.drain", 32'(rsp_valid), 32'd0);

    // DEPTH=8: top index, then one word past the end
    s_load_we = 1'b1; s_load_idx = 3'd7; s_load_data = 32'hDEAD_BEEF;
    step();
    s_load_we = 1'b0; s_req_valid = 1'b1; s_req_pc = 32'h0040_001C; s_rsp_ready = 1'b1;
    step();
    check("top.valid", 32'(s_rsp_valid), 32'd1);
    check("top.instr", s_rsp_instr, 32'hDEAD_BEEF);
    check("top.fault", 32'(s_rsp_fault), 32'd0);
    s_req_pc = 32'h0040_0020;
    step();
    check("wrap.fault", 32'(s_rsp_fault), 32'd2);
    check("wrap.instr", s_rsp_instr, 32'd0);
    check("wrap.pc", s_rsp_pc, 32'h0040_0020);
    s_req_valid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
